// File: rtl/dm_pkg.sv
// Shared definitions for the byte-addressable data memory / load-store unit.
`timescale 1ns/1ps
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dm_load_fmt.sv
// Load formatter: picks the addressed byte/half from a memory word and
// sign- or zero-extends it according to the RV32I funct3 code.
`timescale 1ns/1ps
module dm_load_fmt
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word_i >> {lane_i, 3'b000});
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32I data memory with store lane masking and load formatting.
// Define DM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of masking the low bits.
`timescale 1ns/1ps
module data_mem_lsu
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_e             state_q;
  logic [WAIT_W-1:0]  cnt_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic               cur_we;
  logic [2:0]         cur_f3;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic [31:0]        offset;
  logic [AW-1:0]      idx;
  logic [1:0]         lane;
  logic               fault;
  logic [3:0]         be;
  logic [31:0]        wdata_lanes;
  logic [31:0]        load_fmt;
  logic               enter_resp;
  logic               mem_we;
  logic [31:0]        rsp_rdata_d;

  // With zero wait states the commit edge is the accept edge, so the live
  // request is used until it has been latched.
  assign cur_we    = (state_q == IDLE) ? req_we     : we_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  assign offset = cur_addr - BASE_ADDR;
  assign idx    = offset[AW+1:2];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane        = offset[1:0];
    fault       = |offset[31:AW+2];
    be          = 4'b0000;
    wdata_lanes = cur_wdata;
    case (cur_f3)
      F3_B, F3_BU: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{cur_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        if (ALIGN_CHECK) fault = fault | offset[0];
        else             lane[0] = 1'b0;
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{cur_wdata[15:0]}};
      end
      F3_W: begin
        if (ALIGN_CHECK) fault = fault | (|offset[1:0]);
        else             lane = 2'b00;
        be = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
    if (cur_f3[2] && cur_we) fault = 1'b1;
  end

  dm_load_fmt u_load_fmt (
    .word_i   (mem_q[idx]),
    .lane_i   (lane),
    .funct3_i (cur_f3),
    .data_o   (load_fmt)
  );

  assign enter_resp  = ((state_q == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == '0));
  assign mem_we      = enter_resp && cur_we && !fault && rst;
  assign rsp_rdata_d = (!cur_we && !fault) ? load_fmt : 32'h0;

  // NOTE: the memory array has no reset; its contents are undefined at power-up and survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= fault;
      end
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_W'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - WAIT_W'(1);
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu (default parameters, WAIT_STATES=1).
`timescale 1ns/1ps
module tb_data_mem_lsu;
  import dm_pkg::*;

  localparam int EXP_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request #1 after a rising edge and waits for its response.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
    int lat;
    bit seen;
    check({tag, "_ready_idle"}, req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_ready_busy"}, req_ready, 0);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (seen) check({tag, "_latency"}, lat, EXP_LAT);
    else      check({tag, "_rsp_timeout"}, 0, 1);
    rd  = rsp_rdata;
    err = rsp_err;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, rsp_valid, 0);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    access(tag, we, f3, addr, wd, rd, e);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, e, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_word;
    logic        flag;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err",   rsp_err,   0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    xfer("sw_dead", 1'b1, F3_W, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("lw_dead", 1'b0, F3_W, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);

    xfer("sw_cafe", 1'b1, F3_W,  32'h1000, 32'hCAFEBABE, 32'h0, 1'b0);
    xfer("sb_80",   1'b1, F3_B,  32'h1003, 32'h12345680, 32'h0, 1'b0);
    xfer("lw_sb",   1'b0, F3_W,  32'h1000, 32'h0, 32'h80FEBABE, 1'b0);
    xfer("lb_3",    1'b0, F3_B,  32'h1003, 32'h0, 32'hFFFFFF80, 1'b0);
    xfer("lbu_3",   1'b0, F3_BU, 32'h1003, 32'h0, 32'h00000080, 1'b0);
    xfer("lb_1",    1'b0, F3_B,  32'h1001, 32'h0, 32'hFFFFFFBA, 1'b0);

    xfer("sh_8001", 1'b1, F3_H,  32'h1002, 32'hAAAA8001, 32'h0, 1'b0);
    xfer("lh_2",    1'b0, F3_H,  32'h1002, 32'h0, 32'hFFFF8001, 1'b0);
    xfer("lhu_2",   1'b0, F3_HU, 32'h1002, 32'h0, 32'h00008001, 1'b0);
    xfer("lhu_0",   1'b0, F3_HU, 32'h1000, 32'h0, 32'h0000BABE, 1'b0);
    xfer("lw_sh",   1'b0, F3_W,  32'h1000, 32'h0, 32'h8001BABE, 1'b0);

    xfer("lw_below", 1'b0, F3_W, 32'h0FFC, 32'h0, 32'h0, 1'b1);
    xfer("lw_above", 1'b0, F3_W, 32'h2000, 32'h0, 32'h0, 1'b1);
    xfer("sw_last",  1'b1, F3_W, 32'h1FFC, 32'h0BADF00D, 32'h0, 1'b0);
    xfer("lw_last",  1'b0, F3_W, 32'h1FFC, 32'h0, 32'h0BADF00D, 1'b0);
    xfer("ld_f3_011", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1'b1);
    xfer("st_f3_011", 1'b1, 3'b011, 32'h1000, 32'h11111111, 32'h0, 1'b1);
    xfer("st_f3_100", 1'b1, F3_BU,  32'h1000, 32'h22222222, 32'h0, 1'b1);
    xfer("sw_above",  1'b1, F3_W,   32'h2000, 32'h33333333, 32'h0, 1'b1);
    xfer("lw_nowr",   1'b0, F3_W,   32'h1000, 32'h0, 32'h8001BABE, 1'b0);

`ifdef DM_ALIGN_CHECK_EN
    xfer("sw_mis",  1'b1, F3_W, 32'h1002, 32'h12345678, 32'h0, 1'b1);
    xfer("lw_mis",  1'b0, F3_W, 32'h1000, 32'h0, 32'h8001BABE, 1'b0);
    xfer("lh_mis",  1'b0, F3_H, 32'h1001, 32'h0, 32'h0, 1'b1);
    old_word = 32'h8001BABE;
`else
    xfer("sw_mis",  1'b1, F3_W, 32'h1002, 32'h12345678, 32'h0, 1'b0);
    xfer("lw_mis",  1'b0, F3_W, 32'h1000, 32'h0, 32'h12345678, 1'b0);
    xfer("lh_mis",  1'b0, F3_H, 32'h1001, 32'h0, 32'h00005678, 1'b0);
    old_word = 32'h12345678;
`endif

    // Reset in the WAIT state of a store: no response and no write.
    check("rr_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h1000;
    req_wdata  = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rr_in_wait", req_ready, 0);
    rst = 1'b0;
    #1;
    check("rr_ready_now", req_ready, 1);
    check("rr_valid_now", rsp_valid, 0);
    flag = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      flag = flag | rsp_valid;
    end
    @(negedge clk) rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      flag = flag | rsp_valid;
    end
    check("rr_no_rsp", flag, 0);
    xfer("lw_after_rst", 1'b0, F3_W, 32'h1000, 32'h0, old_word, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
